bcd_mod_counter: RTL and testbench



---
 rtl/bcd_mod_counter.sv | 125 ++++++++++++
 tb/tb_bcd_mod_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with an enable-gated prescaler, up/down stepping,
// synchronous clear and a range-checked parallel load. All outputs are registered.
module bcd_mod_counter #(
  parameter int MODULUS  = 60,
  parameter int PRESCALE = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       tick,
  output logic       tc,
  output logic       load_err
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int              MAXV     = MODULUS - 1;
  localparam logic [3:0]      MAX_T    = 4'(MAXV / 10);
  localparam logic [3:0]      MAX_U    = 4'(MAXV % 10);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]      MOD8     = 8'(MODULUS);

  logic [3:0]    units_q, units_d;
  logic [3:0]    tens_q, tens_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          tc_q, tc_d;
  logic          err_q, err_d;

  logic [3:0] ld_t;
  logic [3:0] ld_u;
  logic [7:0] ld_bin;
  logic       ld_ok;
  logic       step;

  assign ld_t = load_val[7:4];
  assign ld_u = load_val[3:0];
  // tens*10 + units, formed as tens*8 + tens*2 + units
  assign ld_bin = {1'b0, ld_t, 3'b000} + {3'b000, ld_t, 1'b0} + {4'b0000, ld_u};
  assign ld_ok  = (ld_t <= 4'd9) && (ld_u <= 4'd9) && (ld_bin < MOD8);
  assign step   = en && (pre_q == PRE_LAST);

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    if (clr) begin
      units_d = 4'd0;
      tens_d  = 4'd0;
      pre_d   = '0;
    end else if (load) begin
      // a rejected load freezes everything, including a coincident step
      if (ld_ok) begin
        units_d = ld_u;
        tens_d  = ld_t;
        pre_d   = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      if (step) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (up) begin
          if (units_q == MAX_U && tens_q == MAX_T) begin
            units_d = 4'd0;
            tens_d  = 4'd0;
            tc_d    = 1'b1;
          end else if (units_q == 4'd9) begin
            units_d = 4'd0;
            tens_d  = tens_q + 4'd1;
          end else begin
            units_d = units_q + 4'd1;
          end
        end else begin
          if (units_q == 4'd0 && tens_q == 4'd0) begin
            units_d = MAX_U;
            tens_d  = MAX_T;
            tc_d    = 1'b1;
          end else if (units_q == 4'd0) begin
            units_d = 4'd9;
            tens_d  = tens_q - 4'd1;
          end else begin
            units_d = units_q - 4'd1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign units    = units_q;
  assign tens     = tens_q;
  assign tick     = tick_q;
  assign tc       = tc_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench: two counter configurations share one input stream; an
// integer-valued reference model queues expected outputs, per-DUT monitors compare.
module tb_bcd_mod_counter;

  localparam int MOD_A = 60;
  localparam int PRE_A = 4;
  localparam int MOD_B = 100;
  localparam int PRE_B = 1;

  logic       clk = 1'b0;
  logic       reset, en, up, clr, load;
  logic [7:0] load_val;
  logic [3:0] u_a, t_a, u_b, t_b;
  logic       tk_a, tc_a, er_a, tk_b, tc_b, er_b;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MODULUS(MOD_A), .PRESCALE(PRE_A)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .units(u_a), .tens(t_a), .tick(tk_a), .tc(tc_a),
    .load_err(er_a)
  );

  bcd_mod_counter #(.MODULUS(MOD_B), .PRESCALE(PRE_B)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .units(u_b), .tens(t_b), .tick(tk_b), .tc(tc_b),
    .load_err(er_b)
  );

  typedef struct packed {
    logic [3:0] u;
    logic [3:0] t;
    logic       tick;
    logic       tc;
    logic       err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   val_a = 0, pre_a = 0, val_b = 0, pre_b = 0;

  // Reference: count held as a plain integer; stepping is modular arithmetic.
  task automatic model_step(input int modulus, input int ps, inout int val,
                            inout int pre, output exp_t e);
    int lt, lu;
    e  = '0;
    lt = int'(load_val[7:4]);
    lu = int'(load_val[3:0]);
    if (reset || clr) begin
      val = 0;
      pre = 0;
    end else if (load) begin
      if (lt <= 9 && lu <= 9 && (lt * 10 + lu) < modulus) begin
        val = lt * 10 + lu;
        pre = 0;
      end else begin
        e.err = 1'b1;
      end
    end else if (en) begin
      pre = pre + 1;
      if (pre == ps) begin
        pre    = 0;
        e.tick = 1'b1;
        if (up) begin
          e.tc = (val == modulus - 1);
          val  = (val + 1) % modulus;
        end else begin
          e.tc = (val == 0);
          val  = (val + modulus - 1) % modulus;
        end
      end
    end
    e.u = 4'(val % 10);
    e.t = 4'(val / 10);
  endtask

  task automatic cyc(input logic r, input logic e_i, input logic u_i,
                     input logic c_i, input logic l_i, input logic [7:0] lv);
    exp_t ea, eb;
    reset    = r;
    en       = e_i;
    up       = u_i;
    clr      = c_i;
    load     = l_i;
    load_val = lv;
    @(posedge clk);
    model_step(MOD_A, PRE_A, val_a, pre_a, ea);
    model_step(MOD_B, PRE_B, val_b, pre_b, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(negedge clk);
  endtask

  task automatic check(input string name, input exp_t exp, input exp_t act);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got tens=%0d units=%0d tick=%b tc=%b err=%b, expected tens=%0d units=%0d tick=%b tc=%b err=%b",
               name, act.t, act.u, act.tick, act.tc, act.err,
               exp.t, exp.u, exp.tick, exp.tc, exp.err);
    end
  endtask

  always @(negedge clk) begin
    if (q_a.size() > 0) check("mod60_pre4", q_a.pop_front(), {u_a, t_a, tk_a, tc_a, er_a});
    if (q_b.size() > 0) check("mod100_pre1", q_b.pop_front(), {u_b, t_b, tk_b, tc_b, er_b});
  end

  initial begin
    logic       r_i, e_i, u_i, c_i, l_i;
    logic [7:0] lv;
    reset = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;

    repeat (2) cyc(1, 0, 1, 0, 0, 8'h00);
    repeat (12) cyc(0, 1, 1, 0, 0, 8'h00);

    cyc(0, 1, 1, 0, 1, 8'h59);
    repeat (4) cyc(0, 1, 1, 0, 0, 8'h00);

    cyc(0, 1, 0, 0, 1, 8'h00);
    repeat (44) cyc(0, 1, 0, 0, 0, 8'h00);

    cyc(0, 1, 1, 0, 1, 8'h60);
    cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 1, 8'h3A);
    cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 1, 8'h99);
    cyc(0, 1, 1, 0, 1, 8'hA0);

    cyc(0, 1, 1, 0, 1, 8'h10);
    repeat (3) cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(0, 1, 1, 1, 1, 8'h25);
    repeat (4) cyc(0, 1, 1, 0, 0, 8'h00);

    cyc(0, 1, 1, 1, 0, 8'h00);
    repeat (60) cyc(0, 1, 1, 0, 0, 8'h00);
    repeat (5) cyc(0, 0, 1, 0, 0, 8'h00);
    repeat (60) cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(1, 1, 1, 0, 0, 8'h00);
    repeat (6) cyc(0, 1, 1, 0, 0, 8'h00);
    repeat (2) cyc(0, 0, 1, 0, 0, 8'h00);
    repeat (3) cyc(0, 1, 1, 0, 0, 8'h00);

    u_i = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r_i = ($urandom_range(0, 199) == 0);
      c_i = ($urandom_range(0, 99) == 0);
      l_i = ($urandom_range(0, 19) == 0);
      e_i = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 39) == 0) u_i = ~u_i;
      if ($urandom_range(0, 1) == 1)
        lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        lv = 8'($urandom_range(0, 255));
      cyc(r_i, e_i, u_i, c_i, l_i, lv);
    end

    cyc(0, 0, 1, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    vectors++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0",
               q_a.size(), q_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
